alu_uart_ctrl: RTL and testbench

Sequencing controller that turns a byte stream from the UART receiver into ALU operations and returns each result to the UART transmitter. It collects three consecutive bytes (operand A, operand B, opcode), holds them on the ALU inputs, captures `o_alu`, and hands the result byte to the transmitter with a start/done handshake. It sits between `uart_rx`/`uart_tx` and the combinational `alu`. A byte-gap timeout resynchronises the stream.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/byte_timeout.sv | 29 ++
 rtl/alu_uart_ctrl.sv | 113 +++++++++++
 tb/tb_alu_uart_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU datapath and the UART-to-ALU sequencing controller.
package alu_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W-1:0] OP_NOR = 6'b100111;

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_EXEC    = 3'd3;
  localparam logic [2:0] ST_SEND    = 3'd4;
  localparam logic [2:0] ST_WAIT_TX = 3'd5;

  typedef enum logic [2:0] {
    S_WAIT_A  = ST_WAIT_A,
    S_WAIT_B  = ST_WAIT_B,
    S_WAIT_OP = ST_WAIT_OP,
    S_EXEC    = ST_EXEC,
    S_SEND    = ST_SEND,
    S_WAIT_TX = ST_WAIT_TX
  } state_t;

  function automatic logic is_busy(input state_t s);
    return (s == S_EXEC) || (s == S_SEND) || (s == S_WAIT_TX);
  endfunction

endpackage

// File: rtl/byte_timeout.sv
// Saturating inter-byte gap counter; o_expired is high while the count sits at its last value.
module byte_timeout #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (i_clr) begin
      count <= '0;
    end else if (i_en && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  assign o_expired = i_en && !i_clr && (count == LAST);

endmodule

// File: rtl/alu_uart_ctrl.sv
// Collects A, B, opcode bytes from the UART receiver, holds them on the ALU inputs,
// and returns the captured ALU result to the UART transmitter.
module alu_uart_ctrl
  import alu_pkg::*;
#(
  parameter int N_BITS         = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_BITS-1:0] i_rx_data,
  input  logic              i_rx_done,
  input  logic              i_tx_done,
  input  logic [N_BITS-1:0] i_alu_result,
  output logic [N_BITS-1:0] o_dato_A,
  output logic [N_BITS-1:0] o_dato_B,
  output logic [OP_W-1:0]   o_operacion,
  output logic [N_BITS-1:0] o_tx_data,
  output logic              o_tx_start,
  output logic              o_busy,
  output logic              o_drop
);

  state_t            state, state_nx;
  logic [N_BITS-1:0] a_nx, b_nx, tx_data_nx;
  logic [OP_W-1:0]   op_nx;
  logic              accept, expired, tx_start_nx, drop_nx;

  byte_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr     (accept || (state == S_WAIT_A)),
    .i_en      ((state == S_WAIT_B) || (state == S_WAIT_OP)),
    .o_expired (expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_WAIT_A;
      o_dato_A    <= '0;
      o_dato_B    <= '0;
      o_operacion <= '0;
      o_tx_data   <= '0;
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
      o_drop      <= 1'b0;
    end else begin
      state       <= state_nx;
      o_dato_A    <= a_nx;
      o_dato_B    <= b_nx;
      o_operacion <= op_nx;
      o_tx_data   <= tx_data_nx;
      o_tx_start  <= tx_start_nx;
      o_busy      <= is_busy(state_nx);
      o_drop      <= drop_nx;
    end
  end

  // A received byte always takes priority over an expiring gap timer.
  always_comb begin
    state_nx    = state;
    a_nx        = o_dato_A;
    b_nx        = o_dato_B;
    op_nx       = o_operacion;
    tx_data_nx  = o_tx_data;
    tx_start_nx = 1'b0;
    drop_nx     = 1'b0;
    accept      = 1'b0;
    case (state)
      S_WAIT_A: begin
        if (i_rx_done) begin
          a_nx     = i_rx_data;
          accept   = 1'b1;
          state_nx = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (i_rx_done) begin
          b_nx     = i_rx_data;
          accept   = 1'b1;
          state_nx = S_WAIT_OP;
        end else if (expired) begin
          state_nx = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (i_rx_done) begin
          op_nx    = i_rx_data[OP_W-1:0];
          accept   = 1'b1;
          state_nx = S_EXEC;
        end else if (expired) begin
          state_nx = S_WAIT_A;
        end
      end
      S_EXEC: begin
        tx_data_nx = i_alu_result;
        drop_nx    = i_rx_done;
        state_nx   = S_SEND;
      end
      S_SEND: begin
        tx_start_nx = 1'b1;
        drop_nx     = i_rx_done;
        state_nx    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        drop_nx = i_rx_done;
        if (i_tx_done) state_nx = S_WAIT_A;
      end
      default: state_nx = S_WAIT_A;
    endcase
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed and randomized frames against a behavioural ALU / frame reference model.
module tb_alu_uart_ctrl;
  import alu_pkg::*;

  localparam int NB = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] rx_data = '0;
  logic          rx_done = 1'b0;
  logic          tx_done = 1'b0;
  logic [NB-1:0] alu_result;
  logic [NB-1:0] dato_a, dato_b, tx_data;
  logic [5:0]    operacion;
  logic          tx_start, busy, drop;

  int n_total = 0;
  int n_pass  = 0;
  int start_cnt = 0;

  alu_uart_ctrl #(.N_BITS(NB), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rx_data    (rx_data),
    .i_rx_done    (rx_done),
    .i_tx_done    (tx_done),
    .i_alu_result (alu_result),
    .o_dato_A     (dato_a),
    .o_dato_B     (dato_b),
    .o_operacion  (operacion),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy),
    .o_drop       (drop)
  );

  always #5 clk = ~clk;

  function automatic logic [NB-1:0] alu_model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                               input logic [5:0] op);
    logic [NB-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SRA:  r = $signed(a) >>> b;
      OP_SRL:  r = a >> b;
      OP_NOR:  r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

  assign alu_result = alu_model(dato_a, dato_b, operacion);

  always @(negedge clk) if (tx_start === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; the byte is sampled gap+1 rising edges later.
  task automatic send_byte(input logic [NB-1:0] b, input int gap);
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Entered at the negedge right after the opcode edge k.
  // mode 0: plain tx_done; 1: stray byte while waiting, then tx_done; 2: byte and tx_done together.
  task automatic finish_tx(input logic [NB-1:0] exp, input int mode);
    int s0;
    logic [NB-1:0] a0, b0;
    logic [5:0] op0;
    s0 = start_cnt;
    check("busy_exec", 32'(busy), 32'd1);
    check("start_early", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("tx_data_k1", 32'(tx_data), 32'(exp));
    check("start_k1", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("start_k2", 32'(tx_start), 32'd1);
    check("tx_data_k2", 32'(tx_data), 32'(exp));
    @(negedge clk);
    check("start_k3", 32'(tx_start), 32'd0);
    check("start_once", 32'(start_cnt - s0), 32'd1);
    check("busy_wait_tx", 32'(busy), 32'd1);
    a0 = dato_a; b0 = dato_b; op0 = operacion;
    if (mode == 2) begin
      rx_data = 8'h77; rx_done = 1'b1; tx_done = 1'b1;
      @(negedge clk);
      rx_done = 1'b0; tx_done = 1'b0;
      check("drop_simul", 32'(drop), 32'd1);
      check("busy_simul", 32'(busy), 32'd0);
      check("a_simul", 32'(dato_a), 32'(a0));
    end else begin
      if (mode == 1) begin
        send_byte(8'h55, 0);
        check("drop_pulse", 32'(drop), 32'd1);
        check("drop_regs", {8'h0, dato_a, dato_b, 2'b0, operacion}, {8'h0, a0, b0, 2'b0, op0});
        @(negedge clk);
        check("drop_end", 32'(drop), 32'd0);
        check("busy_after_drop", 32'(busy), 32'd1);
      end
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
      check("busy_done", 32'(busy), 32'd0);
    end
    check("tx_data_hold", 32'(tx_data), 32'(exp));
  endtask

  task automatic run_frame(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [NB-1:0] opb,
                           input int ga, input int gb, input int go, input int mode);
    send_byte(a, ga);
    send_byte(b, gb);
    send_byte(opb, go);
    check("op_reg", 32'(operacion), 32'(opb[5:0]));
    check("a_reg", 32'(dato_a), 32'(a));
    check("b_reg", 32'(dato_b), 32'(b));
    finish_tx(alu_model(a, b, opb[5:0]), mode);
  endtask

  task automatic check_zero(input string tag);
    check(tag, {4'h0, dato_a, dato_b, tx_data, operacion, tx_start, busy},
               {4'h0, 8'h0, 8'h0, 8'h0, 6'h0, 1'b0, 1'b0});
    check({tag, "_drop"}, 32'(drop), 32'd0);
  endtask

  initial begin
    logic [5:0] ops [9];
    int s0;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR, 6'h3F};

    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_frame(8'h05, 8'h03, 8'h20, 0, 0, 0, 0);
    check("add_result", 32'(tx_data), 32'h08);

    run_frame(8'hF0, 8'h02, 8'hC3, 0, 2, 1, 0);
    check("sra_op", 32'(operacion), 32'h03);
    check("sra_result", 32'(tx_data), 32'hFC);

    // Gap of TO idle cycles after a lone byte: next byte restarts as A.
    send_byte(8'h11, 0);
    run_frame(8'h07, 8'h01, 8'h22, TO, 0, 0, 0);
    check("resync_a", 32'(dato_a), 32'h07);
    check("resync_result", 32'(tx_data), 32'h06);

    // Byte lands in the expiry cycle itself: still taken as B.
    send_byte(8'hAB, 0);
    send_byte(8'h09, TO - 1);
    send_byte(8'h20, 0);
    check("expiry_a", 32'(dato_a), 32'hAB);
    check("expiry_b", 32'(dato_b), 32'h09);
    finish_tx(8'hB4, 0);

    run_frame(8'h12, 8'h34, 8'h25, 0, 0, 0, 1);
    run_frame(8'h0F, 8'h0C, 8'h26, 0, 0, 0, 0);
    check("after_drop", 32'(tx_data), 32'h03);

    run_frame(8'h01, 8'h01, 8'h20, 0, 0, 0, 2);
    run_frame(8'h40, 8'h02, 8'h02, 0, 0, 0, 0);
    check("after_simul", 32'(tx_data), 32'h10);

    // Reset in WAIT_OP.
    s0 = start_cnt;
    send_byte(8'h21, 0);
    send_byte(8'h22, 0);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_wait_op");
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_wait_op_nostart", 32'(start_cnt - s0), 32'd0);
    run_frame(8'h0A, 8'h0B, 8'h20, 0, 0, 0, 0);
    check("rst_wait_op_next", 32'(tx_data), 32'h15);

    // Reset in SEND, held across the edge that would raise tx_start.
    s0 = start_cnt;
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h20, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_send");
    @(posedge clk);
    #1 check("rst_send_start", 32'(tx_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_send_nostart", 32'(start_cnt - s0), 32'd0);
    run_frame(8'h33, 8'h44, 8'h20, 0, 0, 0, 0);
    check("rst_send_next", 32'(tx_data), 32'h77);

    run_frame(8'hAA, 8'h55, 8'h3F, 0, 0, 0, 0);
    check("unknown_op", 32'(tx_data), 32'h00);

    for (int i = 0; i < 24; i++) begin
      logic [NB-1:0] ra, rb, rop;
      ra  = NB'($urandom);
      rb  = NB'($urandom);
      rop = {2'($urandom), ops[$urandom_range(8, 0)]};
      run_frame(ra, rb, rop, int'($urandom_range(3, 0)), int'($urandom_range(TO - 1, 0)),
                int'($urandom_range(TO - 1, 0)), int'($urandom_range(2, 0)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
